// File: rtl/vga_pkg.sv
// Shared VGA raster types and default 640x480@60 timing.
// Imported by the timing generator and its pixel divider.
package vga_pkg;

    typedef logic [9:0] coord_t;

    localparam int CLK_DIV   = 2;
    localparam bit SYNC_POL  = 1'b0;

    localparam int H_VISIBLE = 640;
    localparam int H_FP      = 16;
    localparam int H_SYNC    = 96;
    localparam int H_BP      = 48;
    localparam int V_VISIBLE = 480;
    localparam int V_FP      = 10;
    localparam int V_SYNC    = 2;
    localparam int V_BP      = 33;

    localparam int H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;

endpackage

// File: rtl/vga_timing_gen_pixel_tick_gen.sv
// Pixel-rate clock enable and registered pixel clock.
// tick marks the Clk edge on which the raster advances.
module pixel_tick_gen #(
    parameter int CLK_DIV = 2
) (
    input  logic Clk,
    input  logic reset_n,
    input  logic en,
    output logic tick,
    output logic pixel_clk
);

    localparam int DW = $clog2(CLK_DIV);
    localparam logic [DW-1:0] LAST = DW'(CLK_DIV - 1);
    localparam logic [DW-1:0] HALF = DW'(CLK_DIV / 2);

    logic [DW-1:0] div;
    logic [DW-1:0] div_next;

    assign tick     = en && (div == LAST);
    assign div_next = tick ? '0 : div + DW'(1);

    // pixel_clk falls with the tick so outputs are stable at its rising edge
    always_ff @(posedge Clk or negedge reset_n) begin
        if (!reset_n) begin
            div       <= '0;
            pixel_clk <= 1'b0;
        end else if (en) begin
            div <= div_next;
            if (tick)
                pixel_clk <= 1'b0;
            else if (div_next == HALF)
                pixel_clk <= 1'b1;
        end
    end

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing: coordinates, blanking, syncs, line/frame pulses.
// Outputs are decoded from the next counter values and registered on tick.
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int CLK_DIV   = vga_pkg::CLK_DIV,
    parameter int H_VISIBLE = vga_pkg::H_VISIBLE,
    parameter int H_FP      = vga_pkg::H_FP,
    parameter int H_SYNC    = vga_pkg::H_SYNC,
    parameter int H_BP      = vga_pkg::H_BP,
    parameter int V_VISIBLE = vga_pkg::V_VISIBLE,
    parameter int V_FP      = vga_pkg::V_FP,
    parameter int V_SYNC    = vga_pkg::V_SYNC,
    parameter int V_BP      = vga_pkg::V_BP,
    parameter bit SYNC_POL  = vga_pkg::SYNC_POL
) (
    input  logic        Clk,
    input  logic        reset_n,
    input  logic        en,
    output logic        pixel_clk,
    output logic        hs,
    output logic        vs,
    output logic        blank,
    output coord_t      DrawX,
    output coord_t      DrawY,
    output logic        line_start,
    output logic        frame_start,
    output logic [15:0] frame_count
);

    localparam int H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;
    localparam coord_t H_LAST = coord_t'(H_TOTAL - 1);
    localparam coord_t V_LAST = coord_t'(V_TOTAL - 1);
    localparam int HS_BEG = H_VISIBLE + H_FP;
    localparam int HS_END = HS_BEG + H_SYNC;
    localparam int VS_BEG = V_VISIBLE + V_FP;
    localparam int VS_END = VS_BEG + V_SYNC;

    if (H_TOTAL > 1024 || V_TOTAL > 1024) begin : g_total_chk
        $error("vga_timing_gen: H_TOTAL and V_TOTAL must be <= 1024");
    end
    if (CLK_DIV < 2) begin : g_div_chk
        $error("vga_timing_gen: CLK_DIV must be >= 2");
    end

    logic   tick;
    coord_t hc;
    coord_t vc;
    coord_t hc_next;
    coord_t vc_next;
    logic   hs_on;
    logic   vs_on;
    logic   home;

    pixel_tick_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_tick (
        .Clk       (Clk),
        .reset_n   (reset_n),
        .en        (en),
        .tick      (tick),
        .pixel_clk (pixel_clk)
    );

    always_comb begin
        hc_next = hc;
        vc_next = vc;
        if (tick) begin
            hc_next = (hc == H_LAST) ? '0 : hc + coord_t'(1);
            if (hc == H_LAST)
                vc_next = (vc == V_LAST) ? '0 : vc + coord_t'(1);
        end
    end

    assign hs_on = (int'(hc_next) >= HS_BEG) && (int'(hc_next) < HS_END);
    assign vs_on = (int'(vc_next) >= VS_BEG) && (int'(vc_next) < VS_END);
    assign home  = (hc_next == '0) && (vc_next == '0);

    // counters start at the last position so the first tick lands on (0,0)
    always_ff @(posedge Clk or negedge reset_n) begin
        if (!reset_n) begin
            hc          <= H_LAST;
            vc          <= V_LAST;
            DrawX       <= '0;
            DrawY       <= '0;
            blank       <= 1'b0;
            hs          <= ~SYNC_POL;
            vs          <= ~SYNC_POL;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
            frame_count <= '0;
        end else begin
            line_start  <= 1'b0;
            frame_start <= 1'b0;
            if (tick) begin
                hc          <= hc_next;
                vc          <= vc_next;
                DrawX       <= hc_next;
                DrawY       <= vc_next;
                blank       <= (int'(hc_next) < H_VISIBLE) &&
                               (int'(vc_next) < V_VISIBLE);
                hs          <= hs_on ? SYNC_POL : ~SYNC_POL;
                vs          <= vs_on ? SYNC_POL : ~SYNC_POL;
                line_start  <= (hc_next == '0);
                frame_start <= home;
                if (home)
                    frame_count <= frame_count + 16'd1;
            end
        end
    end

endmodule
